pixel_framebuffer: RTL



---
 rtl/pixel_framebuffer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/pixel_framebuffer.sv
// pixel_framebuffer: consumer end of the drawer pixel interface.
// Plotted pixels land in an on-chip frame store. The store is scanned out as a
// raster stream with a 1-cycle synchronous read. The block also produces a
// per-frame tick and runs a full-screen clear engine.
// Optional build macro FB_DROP_CNT_EN adds a saturating drop_count output.
// The drop counter counts plots that were discarded.
module pixel_framebuffer #(
  parameter int         H_ACTIVE    = 320,
  parameter int         V_ACTIVE    = 240,
  parameter int         H_TOTAL     = 400,
  parameter int         V_TOTAL     = 262,
  parameter logic [2:0] CLEAR_COLOR = 3'b000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        plot,
  input  logic [8:0]  x,
  input  logic [7:0]  y,
  input  logic [2:0]  color,
  input  logic        clear,
  output logic        clear_busy,
  output logic        clear_done,
  output logic [2:0]  pix_color,
  output logic        pix_valid,
  output logic        line_start,
  output logic        frame_tick
`ifdef FB_DROP_CNT_EN
  ,
  output logic [15:0] drop_count
`endif
);

  localparam int N  = H_ACTIVE * V_ACTIVE;
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [AW-1:0] H_ACT_A = AW'(H_ACTIVE);
  localparam logic [AW-1:0] LAST_A  = AW'(N - 1);
  localparam logic [8:0]    H_ACT_X = 9'(H_ACTIVE);
  localparam logic [7:0]    V_ACT_Y = 8'(V_ACTIVE);
  localparam logic [HW-1:0] H_ACT_H = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_V = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);

  // Linear store address. The row*H_ACTIVE product stays below N whenever
  // the coordinate is in range, so AW bits never overflow for legal pixels.
  function automatic logic [AW-1:0] pix_addr(input logic [AW-1:0] col,
                                             input logic [AW-1:0] row);
    return row * H_ACT_A + col;
  endfunction

  typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_DONE} clr_state_e;

  clr_state_e    state_q;
  logic [AW-1:0] clr_addr_q;
  logic          clear_busy_q, clear_done_q;

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic          h_wrap;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [2:0]    rd_data_q;
  logic          pix_valid_q, line_start_q, frame_tick_q;

  logic          in_range, plot_ok, clearing, wr_en;
  logic [AW-1:0] wr_addr;
  logic [2:0]    wr_data;

  logic [2:0]    store_q [N];

  // Raster next-state: h wraps at H_TOTAL-1, v advances on each h wrap.
  always_comb begin
    h_wrap  = (h_cnt_q == H_LAST);
    h_cnt_d = h_wrap ? '0 : h_cnt_q + HW'(1);
    v_cnt_d = v_cnt_q;
    if (h_wrap) begin
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
    end
  end

  // Free-running raster position counters.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign rd_en   = (h_cnt_q < H_ACT_H) && (v_cnt_q < V_ACT_V);
  assign rd_addr = pix_addr(AW'(h_cnt_q), AW'(v_cnt_q));

  // Write port arbitration: the clear engine owns the write port while it
  // runs. Plots only land while idle and in range. Nothing is written in reset.
  assign in_range = (x < H_ACT_X) && (y < V_ACT_Y);
  assign plot_ok  = plot && in_range && (state_q == ST_IDLE);
  assign clearing = (state_q == ST_CLEAR);
  assign wr_en    = reset_n && (clearing || plot_ok);
  assign wr_addr  = clearing ? clr_addr_q : pix_addr(AW'(x), AW'(y));
  assign wr_data  = clearing ? CLEAR_COLOR : color;

  // Frame store: read-first dual-port RAM. A same-edge write to the address
  // being read returns the old contents.
  always_ff @(posedge clk) begin
    rd_data_q <= store_q[rd_addr];
    if (wr_en) begin
      store_q[wr_addr] <= wr_data;
    end
  end

  // Scan-out qualifiers and frame tick, aligned with the read data.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pix_valid_q  <= 1'b0;
      line_start_q <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      pix_valid_q  <= rd_en;
      line_start_q <= rd_en && (h_cnt_q == '0);
      frame_tick_q <= h_wrap && (v_cnt_q == V_LAST);
    end
  end

  assign pix_color  = pix_valid_q ? rd_data_q : 3'b000;
  assign pix_valid  = pix_valid_q;
  assign line_start = line_start_q;
  assign frame_tick = frame_tick_q;

  // Clear engine: sweep every store entry once, then pulse done for a cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      clr_addr_q   <= '0;
      clear_busy_q <= 1'b0;
      clear_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          clear_done_q <= 1'b0;
          if (clear) begin
            state_q      <= ST_CLEAR;
            clr_addr_q   <= '0;
            clear_busy_q <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (clr_addr_q == LAST_A) begin
            state_q      <= ST_DONE;
            clear_busy_q <= 1'b0;
            clear_done_q <= 1'b1;
          end else begin
            clr_addr_q <= clr_addr_q + AW'(1);
          end
        end
        ST_DONE: begin
          clear_done_q <= 1'b0;
          state_q      <= ST_IDLE;
        end
        default: begin
          state_q      <= ST_IDLE;
          clear_busy_q <= 1'b0;
          clear_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign clear_busy = clear_busy_q;
  assign clear_done = clear_done_q;

`ifdef FB_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  // Saturating count of discarded plots (out of range or engine busy).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      drop_cnt_q <= '0;
    end else if (plot && !plot_ok && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_count = drop_cnt_q;
`endif

endmodule
